// File: rtl/counter_3_pkg.sv
// Shared defaults for the score-RAM sub-phase counter.
package counter_3_pkg;

  localparam int unsigned DEF_MODULO = 3;
  localparam int unsigned DEF_WIDTH  = 2;

endpackage : counter_3_pkg

// File: rtl/counter_3.sv
// Modulo-MODULO up-counter stepping score-RAM sub-phases; `signal` flags the last phase.
module counter_3
  import counter_3_pkg::*;
#(
  parameter int unsigned MODULO = DEF_MODULO,
  parameter int unsigned WIDTH  = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             signal,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULO - 1);

  // Reject parameter sets that cannot represent every count state.
  if (MODULO < 2 || (64'(1) << WIDTH) < 64'(MODULO)) begin : g_bad_param
    $error("counter_3: illegal MODULO/WIDTH combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Out-of-range values (>= MODULO) collapse to 0 on the next enabled edge.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (count_q >= TERM) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign signal = (count_q == TERM);

`ifndef SYNTHESIS
  a_range : assert property (@(posedge clk) disable iff (rst)
    32'(count_q) < MODULO);

  a_decode : assert property (@(posedge clk)
    signal == (count_q == TERM));

  a_hold : assert property (@(posedge clk) disable iff (rst)
    !en |=> $stable(count_q));
`endif

endmodule : counter_3

// File: tb/tb_counter_3.sv
// Scoreboard bench for counter_3 at MODULO=3 and MODULO=4 under directed and random rst/en.
module tb_counter_3;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sig3;
  logic [1:0] cnt3;
  logic       sig4;
  logic [1:0] cnt4;

  typedef struct {
    int cyc;
    int c3;
    bit s3;
    int c4;
    bit s4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m3 = 0;
  int   m4 = 0;
  int   cyc = 0;

  counter_3 dut3 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .signal (sig3),
    .count  (cnt3)
  );

  counter_3 #(.MODULO(4), .WIDTH(2)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .signal (sig4),
    .count  (cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count is the number of enabled edges since reset, taken modulo M.
  task automatic drive(input bit r, input bit e);
    exp_t x;
    rst = r;
    en  = e;
    if (r) begin
      m3 = 0;
      m4 = 0;
    end else if (e) begin
      m3 = (m3 + 1) % 3;
      m4 = (m4 + 1) % 4;
    end
    x.cyc = cyc;
    x.c3  = m3;
    x.s3  = (m3 == 2);
    x.c4  = m4;
    x.s4  = (m4 == 3);
    exp_q.push_back(x);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int cy, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cy, got, want);
    end
  endtask

  // Monitor: compares both instances one time unit after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count3",  x.cyc, int'(cnt3), x.c3);
        chk("signal3", x.cyc, int'(sig3), int'(x.s3));
        chk("count4",  x.cyc, int'(cnt4), x.c4);
        chk("signal4", x.cyc, int'(sig4), int'(x.s4));
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    // Reset held with enable low.
    repeat (5) drive(1'b1, 1'b0);
    // Release reset and enable on the same edge: that edge still resets.
    drive(1'b1, 1'b1);
    repeat (15) drive(1'b0, 1'b1);
    // Step to count 1, hold, then resume through terminal and wrap.
    drive(1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    // Hold at terminal value.
    repeat (3) drive(1'b0, 1'b0);
    // Reset with enable high while at terminal, then restart.
    drive(1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
    end
    @(posedge clk);
    #2;
    chk("drain", cyc, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout cyc=%0d got running want finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_3
